gambit_mem_access: RTL and testbench
====================================

// Module: gambit_mem_access
// PURPOSE
//  Memory access unit that consumes the effective address produced by address generation.
//  Turns one load/store request into one or two Wishbone-style bus cycles on a 64-bit data bus.
//  Two cycles are used when an access straddles an 8-byte boundary.
//  Returns aligned, optionally sign-extended load data or store completion.
//  Sits between the issue/execute stage and the data-cache/bus interface.
// PARAMETERS
//  AMSB      `AMSB  msb of address bus (address width AMSB+1)
//  TMO_CYC   255    bus timeout in cycles (used only when GAMBIT_MEM_TMO_EN is defined)
// PORTS
//  clk_i     in   1       clock; all state updates on rising edge
//  rst_ni    in   1       asynchronous active-low reset
//  req_i     in   1       request valid; accepted when req_i & idle_o
//  idle_o    out  1       unit can accept a request this cycle
//  we_i      in   1       1=store, 0=load
//  sz_i      in   2       00 byte, 01 half(2), 10 word(4), 11 dword(8)
//  sx_i      in   1       sign-extend load result
//  wrap_i    in   1       second-part address wraps within the 256-byte page
//  ma_i      in   AMSB+1  effective byte address
//  dat_i     in   64      store data, right-justified
//  cyc_o     out  1       bus cycle active
//  stb_o     out  1       bus strobe
//  we_o      out  1       bus write enable
//  sel_o     out  8       byte lane selects
//  adr_o     out  AMSB+1  bus address, bits[2:0]=0
//  bdat_o    out  64      bus write data, lane-aligned
//  ack_i     in   1       bus acknowledge
//  err_i     in   1       bus error
//  bdat_i    in   64      bus read data
//  res_v_o   out  1       one-cycle result valid pulse
//  res_o     out  64      load result; 0 for stores
//  err_o     out  1       qualifies res_v_o; access faulted
// BEHAVIOUR
//  Reset: state IDLE; idle_o=1; cyc_o, stb_o, we_o, res_v_o and err_o =0; sel_o=0; adr_o=0; bdat_o=0; res_o=0.
//  States: IDLE -> BUS1 -> (BUS2) -> DONE -> IDLE.
//  IDLE: on req_i, latch all inputs and go to BUS1. idle_o=1 only in IDLE.
//  Split condition: ma_i[2:0] + (1<<sz_i) > 8.
//  BUS1: cyc_o=stb_o=1. adr_o = {ma[AMSB:3],3'b0}. sel_o = size mask << ma[2:0], truncated to 8 bits.
//   On ack_i with split: go to BUS2; else go to DONE. Store data is shifted left by ma[2:0] bytes.
//  BUS2: next address is adr+8. If wrap_i, only bits[7:0] add, with carry discarded; upper bits unchanged.
//   sel_o = the remaining high lanes from bit 0. Store data is the upper remainder.
//   cyc_o stays high between BUS1 and BUS2; stb_o drops for one cycle between the parts.
//  DONE: res_v_o=1 for exactly one cycle, then IDLE. There is no result backpressure.
//   Load: combine the parts, right-justify, zero- or sign-extend to 64 bits per sx_i and sz_i.
//  err_i in any bus state: end the cycle; go to DONE with err_o=1 and res_o=0. BUS2 is skipped.
//  err_i wins over ack_i when both are asserted.
//  Latency with zero-wait bus: request in cycle 0, stb in cycle 1, ack in cycle 1, res_v_o in cycle 2.
//   A split access adds 2 cycles.
//  req_i while not idle is ignored; the requester holds req_i.
//  Reset mid-transfer drops cyc_o and stb_o immediately (async) with no result pulse.
// CONFIGURATION
//  GAMBIT_MEM_TMO_EN defined:
//   An 8-bit-plus counter clears on entering BUS1/BUS2 and counts while waiting for ack_i.
//   At TMO_CYC it aborts as a bus error: err_o=1 in DONE.
//  Undefined: no counter; the unit waits indefinitely for ack_i or err_i.
// STRUCTURE
//  gambit_mem_pkg holds:
//   - state enum {IDLE,BUS1,BUS2,DONE}
//   - size codes
//   - function sz_mask(sz) -> 8-bit lane mask
//   - function is_split(ofs,sz)
//  Sub-module gambit_mem_align: combinational lane shift for store data and sel; load merge and extend.
//  The FSM and timeout counter stay in this module.
// TESTING
//  1 dword load at 0x1000, ack in 1 cycle -> sel_o=FF, adr_o=0x1000, res_v_o in cycle 2, res_o=bdat_i.
//  2 half load sx=1 at 0x1007, wrap=0, bytes 0x80 then 0xFF ->
//    BUS1 adr 0x1000 sel 0x80; BUS2 adr 0x1008 sel 0x01; res_o=0xFFFF_FFFF_FFFF_FF80.
//  3 word store at 0x12FE, wrap=1, dat 0xAABBCCDD ->
//    BUS1 adr 0x12F8 sel 0xC0; BUS2 adr 0x1200 sel 0x03; bdat_o low half=0xAABB.
//  4 err_i in BUS1 of a split access -> no BUS2; res_v_o=1, err_o=1, res_o=0.
//  5 reset asserted in BUS1 -> cyc_o=0 at once; idle_o=1; no res_v_o after release.
//  6 GAMBIT_MEM_TMO_EN, TMO_CYC=4, no ack -> after 4 wait cycles res_v_o=1, err_o=1.

Source files
------------

// File: rtl/gambit_mem_pkg.sv
// Shared types and helpers for the gambit memory access unit.
// AMSB may be overridden with +define+AMSB=<n>; defaults to a 32-bit address bus.
`ifndef AMSB
`define AMSB 31
`endif

package gambit_mem_pkg;

    localparam int AMSB_DEF = `AMSB;

    typedef enum logic [1:0] {IDLE, BUS1, BUS2, DONE} state_e;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    function automatic logic [7:0] sz_mask(input logic [1:0] sz);
        case (sz)
            SZ_B:    return 8'h01;
            SZ_H:    return 8'h03;
            SZ_W:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    // 4 bits hold the worst case 7 + 8
    function automatic logic is_split(input logic [2:0] ofs, input logic [1:0] sz);
        return ({1'b0, ofs} + (4'd1 << sz)) > 4'd8;
    endfunction

endpackage

// File: rtl/gambit_mem_if.sv
// Request/result and Wishbone-style bus signals of the memory access unit.
// master is the access unit; slave is the requester plus bus side.
interface gambit_mem_if #(parameter int AMSB = gambit_mem_pkg::AMSB_DEF);
    logic            req_i;
    logic            idle_o;
    logic            we_i;
    logic [1:0]      sz_i;
    logic            sx_i;
    logic            wrap_i;
    logic [AMSB:0]   ma_i;
    logic [63:0]     dat_i;
    logic            cyc_o;
    logic            stb_o;
    logic            we_o;
    logic [7:0]      sel_o;
    logic [AMSB:0]   adr_o;
    logic [63:0]     bdat_o;
    logic            ack_i;
    logic            err_i;
    logic [63:0]     bdat_i;
    logic            res_v_o;
    logic [63:0]     res_o;
    logic            err_o;

    modport master (
        input  req_i, we_i, sz_i, sx_i, wrap_i, ma_i, dat_i, ack_i, err_i, bdat_i,
        output idle_o, cyc_o, stb_o, we_o, sel_o, adr_o, bdat_o, res_v_o, res_o, err_o
    );

    modport slave (
        output req_i, we_i, sz_i, sx_i, wrap_i, ma_i, dat_i, ack_i, err_i, bdat_i,
        input  idle_o, cyc_o, stb_o, we_o, sel_o, adr_o, bdat_o, res_v_o, res_o, err_o
    );
endinterface

// File: rtl/gambit_mem_align.sv
// Combinational lane steering: store data/sel per bus part, load merge and extend.
module gambit_mem_align
    import gambit_mem_pkg::*;
(
    input  logic [2:0]  ofs,
    input  logic [1:0]  sz,
    input  logic        sx,
    input  logic        part,
    input  logic [63:0] dat,
    input  logic [63:0] lo,
    input  logic [63:0] hi,
    output logic [7:0]  sel,
    output logic [63:0] wdat,
    output logic [63:0] res
);
    logic [15:0]  m16;
    logic [127:0] w128;
    logic [127:0] r128;
    logic [63:0]  raw;

    // The upper half of each double-width shift is what spills into the second part
    always_comb begin
        m16  = {8'h00, sz_mask(sz)} << ofs;
        w128 = {64'h0, dat} << {ofs, 3'b000};
        r128 = {hi, lo} >> {ofs, 3'b000};
        raw  = r128[63:0];
        sel  = part ? m16[15:8] : m16[7:0];
        wdat = part ? w128[127:64] : w128[63:0];
        case (sz)
            SZ_B:    res = {{56{sx & raw[7]}},  raw[7:0]};
            SZ_H:    res = {{48{sx & raw[15]}}, raw[15:0]};
            SZ_W:    res = {{32{sx & raw[31]}}, raw[31:0]};
            default: res = raw;
        endcase
    end
endmodule

// File: rtl/gambit_mem_access.sv
// Load/store unit: one request becomes one or two 64-bit bus cycles.
// Optional bus timeout enabled by defining GAMBIT_MEM_TMO_EN (limit TMO_CYC).
module gambit_mem_access
    import gambit_mem_pkg::*;
#(
    parameter int AMSB = AMSB_DEF
`ifdef GAMBIT_MEM_TMO_EN
    , parameter int TMO_CYC = 255
`endif
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    gambit_mem_if.master m
);
    state_e        state;
    logic          we_q;
    logic [1:0]    sz_q;
    logic          sx_q;
    logic          wrap_q;
    logic          split_q;
    logic [2:0]    ofs_q;
    logic [63:0]   dat_q;
    logic [63:0]   rd_lo;
    logic [AMSB:0] adr_nxt;
    logic          in_idle;
    logic [7:0]    al_sel;
    logic [63:0]   al_wdat;
    logic [63:0]   al_res;
`ifdef GAMBIT_MEM_TMO_EN
    logic [8:0]    cnt;
`endif

    assign in_idle = (state == IDLE);
    assign adr_nxt = wrap_q ? {m.adr_o[AMSB:8], m.adr_o[7:0] + 8'd8}
                            : m.adr_o + (AMSB+1)'(8);

    // In IDLE the aligner sees live request inputs so BUS1 outputs can be registered directly
    gambit_mem_align u_align (
        .ofs  (in_idle ? m.ma_i[2:0] : ofs_q),
        .sz   (in_idle ? m.sz_i : sz_q),
        .sx   (sx_q),
        .part (!in_idle),
        .dat  (in_idle ? m.dat_i : dat_q),
        .lo   ((state == BUS2) ? rd_lo : m.bdat_i),
        .hi   (m.bdat_i),
        .sel  (al_sel),
        .wdat (al_wdat),
        .res  (al_res)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            m.idle_o  <= 1'b1;
            m.cyc_o   <= 1'b0;
            m.stb_o   <= 1'b0;
            m.we_o    <= 1'b0;
            m.sel_o   <= '0;
            m.adr_o   <= '0;
            m.bdat_o  <= '0;
            m.res_v_o <= 1'b0;
            m.res_o   <= '0;
            m.err_o   <= 1'b0;
            we_q    <= 1'b0;
            sz_q    <= '0;
            sx_q    <= 1'b0;
            wrap_q  <= 1'b0;
            split_q <= 1'b0;
            ofs_q   <= '0;
            dat_q   <= '0;
            rd_lo   <= '0;
`ifdef GAMBIT_MEM_TMO_EN
            cnt     <= '0;
`endif
        end else begin
            m.res_v_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (m.req_i) begin
                        state   <= BUS1;
                        we_q    <= m.we_i;
                        sz_q    <= m.sz_i;
                        sx_q    <= m.sx_i;
                        wrap_q  <= m.wrap_i;
                        split_q <= is_split(m.ma_i[2:0], m.sz_i);
                        ofs_q   <= m.ma_i[2:0];
                        dat_q   <= m.dat_i;
                        m.idle_o <= 1'b0;
                        m.cyc_o  <= 1'b1;
                        m.stb_o  <= 1'b1;
                        m.we_o   <= m.we_i;
                        m.adr_o  <= {m.ma_i[AMSB:3], 3'b000};
                        m.sel_o  <= al_sel;
                        m.bdat_o <= m.we_i ? al_wdat : 64'h0;
`ifdef GAMBIT_MEM_TMO_EN
                        cnt     <= '0;
`endif
                    end
                end
                BUS1, BUS2: begin
                    if (m.err_i || (m.stb_o && m.ack_i && !(state == BUS1 && split_q))) begin
                        state     <= DONE;
                        m.cyc_o   <= 1'b0;
                        m.stb_o   <= 1'b0;
                        m.we_o    <= 1'b0;
                        m.sel_o   <= '0;
                        m.bdat_o  <= '0;
                        m.res_v_o <= 1'b1;
                        m.err_o   <= m.err_i;
                        m.res_o   <= (m.err_i || we_q) ? 64'h0 : al_res;
                    end else if (m.stb_o && m.ack_i) begin
                        // First half of a split access; stb drops for one cycle
                        state    <= BUS2;
                        rd_lo    <= m.bdat_i;
                        m.stb_o  <= 1'b0;
                        m.adr_o  <= adr_nxt;
                        m.sel_o  <= al_sel;
                        m.bdat_o <= we_q ? al_wdat : 64'h0;
`ifdef GAMBIT_MEM_TMO_EN
                        cnt      <= '0;
`endif
                    end else if (!m.stb_o) begin
                        m.stb_o <= 1'b1;
                    end
`ifdef GAMBIT_MEM_TMO_EN
                    else if (cnt == 9'(TMO_CYC - 1)) begin
                        state     <= DONE;
                        m.cyc_o   <= 1'b0;
                        m.stb_o   <= 1'b0;
                        m.we_o    <= 1'b0;
                        m.sel_o   <= '0;
                        m.bdat_o  <= '0;
                        m.res_v_o <= 1'b1;
                        m.err_o   <= 1'b1;
                        m.res_o   <= 64'h0;
                    end else begin
                        cnt <= cnt + 9'd1;
                    end
`endif
                end
                DONE: begin
                    state    <= IDLE;
                    m.idle_o <= 1'b1;
                    m.err_o  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gambit_mem_access.sv
// Self-checking bench for gambit_mem_access: vector table plus scoreboard of results.
module tb_gambit_mem_access;
    import gambit_mem_pkg::*;

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        sx;
        logic        wrap;
        logic [31:0] ma;
        logic [63:0] dat;
        logic [63:0] rd1;
        logic [63:0] rd2;
        logic        split;
        logic [31:0] adr1;
        logic [7:0]  sel1;
        logic [63:0] bd1;
        logic [31:0] adr2;
        logic [7:0]  sel2;
        logic [63:0] bd2;
        logic [63:0] res;
    } vec_t;

    typedef struct {
        logic [63:0] res;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   compared = 0;
    int   mismatched = 0;
    int   rv_cnt = 0;
    exp_t sb[$];
    vec_t vecs[12];

    gambit_mem_if #(.AMSB(31)) bus ();

`ifdef GAMBIT_MEM_TMO_EN
    gambit_mem_access #(.AMSB(31), .TMO_CYC(4)) dut (.clk_i(clk), .rst_ni(rst_n), .m(bus));
`else
    gambit_mem_access #(.AMSB(31)) dut (.clk_i(clk), .rst_ni(rst_n), .m(bus));
`endif

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.res_v_o) begin
            exp_t e;
            rv_cnt++;
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_result actual res_v=1 required no result");
            end else begin
                e = sb.pop_front();
                chk("sb_res", bus.res_o, e.res);
                chk("sb_err", 64'(bus.err_o), 64'(e.err));
            end
        end
    end

    task automatic drive_req(input vec_t v);
        @(negedge clk);
        bus.req_i  = 1'b1;
        bus.we_i   = v.we;
        bus.sz_i   = v.sz;
        bus.sx_i   = v.sx;
        bus.wrap_i = v.wrap;
        bus.ma_i   = v.ma;
        bus.dat_i  = v.dat;
        @(posedge clk); #1;
        bus.req_i = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        exp_t e;
        e.res = v.we ? 64'h0 : v.res;
        e.err = 1'b0;
        sb.push_back(e);
        drive_req(v);
        chk($sformatf("v%0d_stb1", idx), 64'(bus.stb_o), 64'd1);
        chk($sformatf("v%0d_adr1", idx), 64'(bus.adr_o), 64'(v.adr1));
        chk($sformatf("v%0d_sel1", idx), 64'(bus.sel_o), 64'(v.sel1));
        chk($sformatf("v%0d_we1", idx), 64'(bus.we_o), 64'(v.we));
        if (v.we) chk($sformatf("v%0d_bd1", idx), bus.bdat_o, v.bd1);
        bus.ack_i = 1'b1; bus.bdat_i = v.rd1;
        @(posedge clk); #1;
        bus.ack_i = 1'b0;
        if (v.split) begin
            chk($sformatf("v%0d_gap", idx), {62'h0, bus.cyc_o, bus.stb_o}, 64'b10);
            @(posedge clk); #1;
            chk($sformatf("v%0d_stb2", idx), 64'(bus.stb_o), 64'd1);
            chk($sformatf("v%0d_adr2", idx), 64'(bus.adr_o), 64'(v.adr2));
            chk($sformatf("v%0d_sel2", idx), 64'(bus.sel_o), 64'(v.sel2));
            if (v.we) chk($sformatf("v%0d_bd2", idx), bus.bdat_o, v.bd2);
            bus.ack_i = 1'b1; bus.bdat_i = v.rd2;
            @(posedge clk); #1;
            bus.ack_i = 1'b0;
        end
        chk($sformatf("v%0d_resv", idx), {62'h0, bus.res_v_o, bus.cyc_o}, 64'b10);
        @(posedge clk); #1;
        chk($sformatf("v%0d_idle", idx), 64'(bus.idle_o), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  v;
        exp_t  e;
        int    n;
        int    rv_before;

        //          we   sz    sx   wrap ma            dat                    rd1                    rd2                    sp   adr1          sel1   bd1                    adr2          sel2   bd2                    res
        vecs[0]  = '{1'b0, SZ_D, 1'b0, 1'b0, 32'h0000_1000, 64'h0, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0, 32'h0000_1000, 8'hFF, 64'h0, 32'h0, 8'h00, 64'h0, 64'h0123_4567_89AB_CDEF};
        vecs[1]  = '{1'b0, SZ_H, 1'b1, 1'b0, 32'h0000_1007, 64'h0, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_00FF, 1'b1, 32'h0000_1000, 8'h80, 64'h0, 32'h0000_1008, 8'h01, 64'h0, 64'hFFFF_FFFF_FFFF_FF80};
        vecs[2]  = '{1'b1, SZ_W, 1'b0, 1'b1, 32'h0000_12FE, 64'hAABB_CCDD, 64'h0, 64'h0, 1'b1, 32'h0000_12F8, 8'hC0, 64'hCCDD_0000_0000_0000, 32'h0000_1200, 8'h03, 64'h0000_0000_0000_AABB, 64'h0};
        vecs[3]  = '{1'b0, SZ_B, 1'b1, 1'b0, 32'h0000_2003, 64'h0, 64'h0000_0000_F100_0000, 64'h0, 1'b0, 32'h0000_2000, 8'h08, 64'h0, 32'h0, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FFF1};
        vecs[4]  = '{1'b0, SZ_B, 1'b0, 1'b0, 32'h0000_2003, 64'h0, 64'h0000_0000_F100_0000, 64'h0, 1'b0, 32'h0000_2000, 8'h08, 64'h0, 32'h0, 8'h00, 64'h0, 64'h0000_0000_0000_00F1};
        vecs[5]  = '{1'b0, SZ_W, 1'b1, 1'b0, 32'h0000_3004, 64'h0, 64'h8765_4321_0000_0000, 64'h0, 1'b0, 32'h0000_3000, 8'hF0, 64'h0, 32'h0, 8'h00, 64'h0, 64'hFFFF_FFFF_8765_4321};
        vecs[6]  = '{1'b0, SZ_W, 1'b0, 1'b0, 32'h0000_3004, 64'h0, 64'h8765_4321_0000_0000, 64'h0, 1'b0, 32'h0000_3000, 8'hF0, 64'h0, 32'h0, 8'h00, 64'h0, 64'h0000_0000_8765_4321};
        vecs[7]  = '{1'b1, SZ_H, 1'b0, 1'b0, 32'h0000_4002, 64'h1234, 64'h0, 64'h0, 1'b0, 32'h0000_4000, 8'h0C, 64'h0000_0000_1234_0000, 32'h0, 8'h00, 64'h0, 64'h0};
        vecs[8]  = '{1'b1, SZ_D, 1'b0, 1'b0, 32'h0000_50F9, 64'h1122_3344_5566_7788, 64'h0, 64'h0, 1'b1, 32'h0000_50F8, 8'hFE, 64'h2233_4455_6677_8800, 32'h0000_5100, 8'h01, 64'h0000_0000_0000_0011, 64'h0};
        vecs[9]  = '{1'b0, SZ_D, 1'b0, 1'b1, 32'h0000_60FC, 64'h0, 64'hDDCC_BBAA_1234_5678, 64'h5555_5555_4433_2211, 1'b1, 32'h0000_60F8, 8'hF0, 64'h0, 32'h0000_6000, 8'h0F, 64'h0, 64'h4433_2211_DDCC_BBAA};
        vecs[10] = '{1'b0, SZ_H, 1'b1, 1'b0, 32'h0000_7006, 64'h0, 64'h8001_0000_0000_0000, 64'h0, 1'b0, 32'h0000_7000, 8'hC0, 64'h0, 32'h0, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_8001};
        vecs[11] = '{1'b0, SZ_W, 1'b0, 1'b0, 32'h0000_10FD, 64'h0, 64'hAABB_CC00_0000_0000, 64'h0000_0000_0000_009E, 1'b1, 32'h0000_10F8, 8'hE0, 64'h0, 32'h0000_1100, 8'h01, 64'h0, 64'h0000_0000_9EAA_BBCC};

        bus.req_i = 1'b0; bus.we_i = 1'b0; bus.sz_i = '0; bus.sx_i = 1'b0; bus.wrap_i = 1'b0;
        bus.ma_i = '0; bus.dat_i = '0; bus.ack_i = 1'b0; bus.err_i = 1'b0; bus.bdat_i = '0;

        #23;
        chk("rst_idle", 64'(bus.idle_o), 64'd1);
        chk("rst_bus", {59'h0, bus.cyc_o, bus.stb_o, bus.we_o, bus.res_v_o, bus.err_o}, 64'h0);
        chk("rst_sel", 64'(bus.sel_o), 64'h0);
        chk("rst_adr", 64'(bus.adr_o), 64'h0);
        chk("rst_bdat", bus.bdat_o, 64'h0);
        chk("rst_res", bus.res_o, 64'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // Error in the first part of a split access: no second part
        v = vecs[1];
        e.res = 64'h0; e.err = 1'b1; sb.push_back(e);
        drive_req(v);
        chk("err_stb1", 64'(bus.stb_o), 64'd1);
        bus.err_i = 1'b1;
        @(posedge clk); #1;
        bus.err_i = 1'b0;
        chk("err_done", {61'h0, bus.res_v_o, bus.err_o, bus.cyc_o}, 64'b110);
        n = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (bus.stb_o) n++;
        end
        chk("err_no_bus2", 64'(n), 64'd0);

        // err_i together with ack_i is treated as an error
        v = vecs[0];
        e.res = 64'h0; e.err = 1'b1; sb.push_back(e);
        drive_req(v);
        bus.err_i = 1'b1; bus.ack_i = 1'b1; bus.bdat_i = '1;
        @(posedge clk); #1;
        bus.err_i = 1'b0; bus.ack_i = 1'b0;
        chk("errack_done", {62'h0, bus.res_v_o, bus.err_o}, 64'b11);
        @(posedge clk); #1;

        // Reset in BUS1: bus drops at once, no result afterwards
        rv_before = rv_cnt;
        drive_req(vecs[0]);
        chk("rstmid_cyc_before", 64'(bus.cyc_o), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_cyc", {62'h0, bus.cyc_o, bus.stb_o}, 64'b00);
        chk("rstmid_idle", 64'(bus.idle_o), 64'd1);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("rstmid_no_result", 64'(rv_cnt), 64'(rv_before));

`ifdef GAMBIT_MEM_TMO_EN
        e.res = 64'h0; e.err = 1'b1; sb.push_back(e);
        drive_req(vecs[0]);
        n = 1;
        while (!bus.res_v_o && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("tmo_latency", 64'(n), 64'd5);
        chk("tmo_err", 64'(bus.err_o), 64'd1);
        @(posedge clk); #1;
`endif

        @(posedge clk); #1;
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
